port_receive_arbiter: RTL and testbench

- Round-robin frame arbiter between the per-port receive streams (RMII and virtual UDP ports) and the single core receive datapath feeding the forwarding/CAM lookup logic.
- Grants one port per frame and streams its 9-bit words (bit 8 = end-of-frame, bits 7:0 = byte) into one registered output.
- Enforces frame-length and stall-timeout limits so a misbehaving port cannot hold the core.

---
 rtl/switch_core_package.sv | 17 +
 rtl/round_robin_picker.sv | 33 +++
 rtl/port_receive_arbiter.sv | 157 +++++++++++++++
 tb/tb_port_receive_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_core_package.sv
// Shared types and constants for the switch core receive/transmit paths.
package switch_core_package;

  localparam int WORD_WIDTH       = 9;
  localparam int END_OF_FRAME_BIT = 8;

  typedef enum logic {
    IDLE,
    STREAM
  } arb_state_t;

  typedef struct packed {
    logic start;
    logic error;
  } frame_status_t;

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin picker: first requester after the pointer,
// wrapping, as a one-hot grant plus its index.
module round_robin_picker #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  request_i,
  input  logic [IW-1:0] pointer_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] index_o,
  output logic          any_o
);

  int j;

  // Scan farthest-first so the nearest requester is the last write.
  always_comb begin
    grant_o = '0;
    index_o = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(pointer_i) + k) % N;
      if (request_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        index_o    = IW'(j);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/port_receive_arbiter.sv
// Round-robin frame arbiter from per-port receive streams into the core
// datapath, with frame-length truncation and stall timeout.
module port_receive_arbiter
  import switch_core_package::*;
#(
  parameter  int NUMBER_OF_PORTS = 2,
  parameter  int MAX_FRAME_BYTES = 1522,
  parameter  int TIMEOUT_CYCLES  = 4096,
  localparam int IW = $clog2(NUMBER_OF_PORTS),
  localparam int BW = $clog2(MAX_FRAME_BYTES),
  localparam int SW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic [NUMBER_OF_PORTS-1:0]                  port_receive_data_valid,
  input  logic [NUMBER_OF_PORTS-1:0][WORD_WIDTH-1:0]  port_receive_data,
  output logic [NUMBER_OF_PORTS-1:0]                  port_receive_data_ready,
  input  logic                                        core_ready,
  output logic [WORD_WIDTH-1:0]                       core_data,
  output logic                                        core_data_valid,
  output logic [IW-1:0]                               core_port_index,
  output logic                                        core_frame_start,
  output logic                                        core_frame_error
);

  arb_state_t                 state_q, state_d;
  logic [NUMBER_OF_PORTS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]              index_q, index_d;
  logic [IW-1:0]              ptr_q, ptr_d;
  logic [BW-1:0]              bytes_q, bytes_d;
  logic [SW-1:0]              stall_q, stall_d;
  logic                       first_q, first_d;
  logic [WORD_WIDTH-1:0]      data_q, data_d;
  logic                       valid_q, valid_d;
  frame_status_t              status_q, status_d;

  logic [NUMBER_OF_PORTS-1:0] pick_gnt;
  logic [IW-1:0]              pick_idx;
  logic                       pick_any;
  logic [WORD_WIDTH-1:0]      word;
  logic                       out_free, xfer, eof, trunc, stalled;

  round_robin_picker #(.N(NUMBER_OF_PORTS)) u_picker (
    .request_i (port_receive_data_valid),
    .pointer_i (ptr_q),
    .grant_o   (pick_gnt),
    .index_o   (pick_idx),
    .any_o     (pick_any)
  );

  assign out_free = !valid_q || core_ready;
  assign word     = port_receive_data[index_q];
  assign eof      = word[END_OF_FRAME_BIT];
  assign xfer     = (state_q == STREAM) && out_free
                    && port_receive_data_valid[index_q];
  assign trunc    = (bytes_q == BW'(MAX_FRAME_BYTES - 1)) && !eof;
  assign stalled  = (stall_q == SW'(TIMEOUT_CYCLES - 1));

  assign port_receive_data_ready =
    (state_q == STREAM && out_free) ? gnt_q : '0;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    index_d  = index_q;
    ptr_d    = ptr_q;
    bytes_d  = bytes_q;
    stall_d  = stall_q;
    first_d  = first_q;
    data_d   = data_q;
    valid_d  = valid_q;
    status_d = status_q;
    if (valid_q && core_ready) begin
      valid_d  = 1'b0;
      data_d   = '0;
      status_d = '0;
    end
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = STREAM;
          gnt_d   = pick_gnt;
          index_d = pick_idx;
          bytes_d = '0;
          stall_d = '0;
          first_d = 1'b1;
        end
      end
      STREAM: begin
        if (xfer) begin
          valid_d        = 1'b1;
          data_d         = word;
          status_d.start = first_q;
          status_d.error = trunc;
          first_d        = 1'b0;
          stall_d        = '0;
          if (trunc) data_d[END_OF_FRAME_BIT] = 1'b1;
          if (eof || trunc) begin
            state_d = IDLE;
            ptr_d   = index_q;
            bytes_d = '0;
          end else if (bytes_q != BW'(MAX_FRAME_BYTES - 1)) begin
            bytes_d = bytes_q + 1'b1;
          end
        end else if (out_free) begin
          // A held output register never counts toward the stall limit.
          if (stalled) begin
            valid_d  = 1'b1;
            data_d   = '0;
            data_d[END_OF_FRAME_BIT] = 1'b1;
            status_d = '{start: 1'b0, error: 1'b1};
            state_d  = IDLE;
            ptr_d    = index_q;
            bytes_d  = '0;
            stall_d  = '0;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      index_q  <= '0;
      ptr_q    <= IW'(NUMBER_OF_PORTS - 1);
      bytes_q  <= '0;
      stall_q  <= '0;
      first_q  <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      index_q  <= index_d;
      ptr_q    <= ptr_d;
      bytes_q  <= bytes_d;
      stall_q  <= stall_d;
      first_q  <= first_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      status_q <= status_d;
    end
  end

  assign core_data        = data_q;
  assign core_data_valid  = valid_q;
  assign core_port_index  = index_q;
  assign core_frame_start = status_q.start;
  assign core_frame_error = status_q.error;

endmodule

// File: tb/tb_port_receive_arbiter.sv
// Scoreboard bench for port_receive_arbiter: directed frames, expected
// words queued up front, a monitor pops on every core transfer.
module tb_port_receive_arbiter;

  localparam int N = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     vld   = '0;
  logic [N-1:0][8:0] dat  = '0;
  logic [N-1:0]     rdy;
  logic             core_rdy = 1'b1;
  logic [8:0]       core_data;
  logic             core_data_valid;
  logic [0:0]       core_port_index;
  logic             core_frame_start;
  logic             core_frame_error;

  typedef struct {
    logic [8:0] d;
    logic       s;
    logic       e;
    int         i;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   lat    = 0;

  port_receive_arbiter #(
    .NUMBER_OF_PORTS (N),
    .MAX_FRAME_BYTES (8),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .port_receive_data_valid (vld),
    .port_receive_data       (dat),
    .port_receive_data_ready (rdy),
    .core_ready              (core_rdy),
    .core_data               (core_data),
    .core_data_valid         (core_data_valid),
    .core_port_index         (core_port_index),
    .core_frame_start        (core_frame_start),
    .core_frame_error        (core_frame_error)
  );

  always #5 clock = ~clock;

  function automatic void expect_w(input logic [8:0] d, input logic s,
                                   input logic e, input int i);
    exp_t x;
    x.d = d; x.s = s; x.e = e; x.i = i;
    q.push_back(x);
  endfunction

  // Called at a negedge; returns at the negedge after the word is taken.
  task automatic send_word(input int p, input logic [8:0] w);
    int n;
    vld[p] = 1'b1;
    dat[p] = w;
    n = 0;
    forever begin
      #1;
      if (rdy[p]) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: port %0d word %h never accepted", p, w);
        return;
      end
      @(negedge clock);
    end
    lat = n;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({core_data_valid, core_data, core_frame_start, core_frame_error,
         core_port_index, rdy} != '0) begin
      errors++;
      $display("FAIL %s: got v=%b d=%h s=%b e=%b i=%0d rdy=%b, expected all 0",
               name, core_data_valid, core_data, core_frame_start,
               core_frame_error, core_port_index, rdy);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clock);
      #2;
      if (!reset) begin
        checks++;
        if (!$onehot0(rdy)) begin
          errors++;
          $display("FAIL ready_onehot: got %b, expected at most one bit", rdy);
        end
        if (core_data_valid && core_rdy) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL extra_word: got d=%h s=%b e=%b i=%0d, expected none",
                     core_data, core_frame_start, core_frame_error,
                     core_port_index);
          end else begin
            x = q.pop_front();
            if (core_data !== x.d || core_frame_start !== x.s ||
                core_frame_error !== x.e || int'(core_port_index) != x.i) begin
              errors++;
              $display("FAIL word: got d=%h s=%b e=%b i=%0d, expected d=%h s=%b e=%b i=%0d",
                       core_data, core_frame_start, core_frame_error,
                       core_port_index, x.d, x.s, x.e, x.i);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    repeat (3) @(negedge clock);
    #1 check_idle("reset_state");
    @(negedge clock);
    reset = 1'b0;

    // Single frame from port 0, checking handshake latency.
    expect_w(9'h001, 1, 0, 0);
    expect_w(9'h002, 0, 0, 0);
    expect_w(9'h003, 0, 0, 0);
    expect_w(9'h103, 0, 0, 0);
    send_word(0, 9'h001);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL ready_latency: got %0d wait cycles, expected 1", lat);
    end
    #1;
    checks++;
    if (!(core_data_valid && core_data == 9'h001 && core_frame_start)) begin
      errors++;
      $display("FAIL first_word: got v=%b d=%h s=%b, expected v=1 d=001 s=1",
               core_data_valid, core_data, core_frame_start);
    end
    send_word(0, 9'h002);
    send_word(0, 9'h003);
    send_word(0, 9'h103);
    vld[0] = 1'b0;
    repeat (3) @(negedge clock);

    // Both ports contend; port 0 just finished so port 1 goes first.
    expect_w(9'h0B0, 1, 0, 1); expect_w(9'h1B1, 0, 0, 1);
    expect_w(9'h0A0, 1, 0, 0); expect_w(9'h1A1, 0, 0, 0);
    expect_w(9'h0B2, 1, 0, 1); expect_w(9'h1B3, 0, 0, 1);
    expect_w(9'h0A2, 1, 0, 0); expect_w(9'h1A3, 0, 0, 0);
    fork
      begin
        send_word(0, 9'h0A0); send_word(0, 9'h1A1);
        send_word(0, 9'h0A2); send_word(0, 9'h1A3);
        vld[0] = 1'b0;
      end
      begin
        send_word(1, 9'h0B0); send_word(1, 9'h1B1);
        send_word(1, 9'h0B2); send_word(1, 9'h1B3);
        vld[1] = 1'b0;
      end
    join
    repeat (3) @(negedge clock);

    // Backpressure mid-frame, longer than the stall limit.
    expect_w(9'h021, 1, 0, 0); expect_w(9'h022, 0, 0, 0);
    expect_w(9'h023, 0, 0, 0); expect_w(9'h124, 0, 0, 0);
    send_word(0, 9'h021);
    send_word(0, 9'h022);
    core_rdy = 1'b0;
    dat[0]   = 9'h023;
    for (int k = 0; k < 20; k++) begin
      #1;
      checks++;
      if (!(core_data_valid && core_data == 9'h022 && rdy == '0)) begin
        errors++;
        $display("FAIL hold_%0d: got v=%b d=%h rdy=%b, expected v=1 d=022 rdy=00",
                 k, core_data_valid, core_data, rdy);
      end
      @(negedge clock);
    end
    core_rdy = 1'b1;
    send_word(0, 9'h023);
    send_word(0, 9'h124);
    vld[0] = 1'b0;
    repeat (3) @(negedge clock);

    // Port 0 stalls after one word; timeout, then port 1 served.
    expect_w(9'h031, 1, 0, 0);
    expect_w(9'h100, 0, 1, 0);
    expect_w(9'h041, 1, 0, 1);
    expect_w(9'h142, 0, 0, 1);
    send_word(0, 9'h031);
    vld[0] = 1'b0;
    send_word(1, 9'h041);
    send_word(1, 9'h142);
    vld[1] = 1'b0;
    repeat (3) @(negedge clock);

    // Overlong frame truncated at 8 words; remainder is a new frame.
    expect_w(9'h051, 1, 0, 0);
    for (int k = 2; k <= 7; k++) expect_w(9'(9'h050 + k), 0, 0, 0);
    expect_w(9'h158, 0, 1, 0);
    expect_w(9'h059, 1, 0, 0);
    expect_w(9'h15A, 0, 0, 0);
    for (int k = 1; k <= 9; k++) send_word(0, 9'(9'h050 + k));
    send_word(0, 9'h15A);
    vld[0] = 1'b0;
    repeat (3) @(negedge clock);

    // Reset mid-frame: partial frame dropped, port 0 has priority after.
    expect_w(9'h061, 1, 0, 0);
    expect_w(9'h062, 0, 0, 0);
    send_word(0, 9'h061);
    send_word(0, 9'h062);
    dat[0] = 9'h063;
    @(negedge clock);
    reset    = 1'b1;
    core_rdy = 1'b0;
    @(negedge clock);
    #1 check_idle("mid_frame_reset");
    @(negedge clock);
    reset    = 1'b0;
    core_rdy = 1'b1;
    expect_w(9'h081, 1, 0, 0); expect_w(9'h182, 0, 0, 0);
    expect_w(9'h071, 1, 0, 1); expect_w(9'h172, 0, 0, 1);
    fork
      begin
        send_word(0, 9'h081); send_word(0, 9'h182);
        vld[0] = 1'b0;
      end
      begin
        send_word(1, 9'h071); send_word(1, 9'h172);
        vld[1] = 1'b0;
      end
    join

    for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clock);
    repeat (3) @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d words still expected, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
